// File: rtl/rs_bank_pkg.sv
// rs_bank_pkg: shared packet types, widths and the reset NOP packet for the reservation-station bank
package rs_bank_pkg;
  localparam int XLEN = 32;
  localparam int ROB_LEN = 16;
  localparam int TAG_BITS = $clog2(ROB_LEN);
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic [31:0] inst;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } ID_PACKET;
  typedef struct packed {
    logic rs1_ready;
    logic [TAG_BITS-1:0] rs1_tag;
    logic rs2_ready;
    logic [TAG_BITS-1:0] rs2_tag;
  } MT2RS_PACKET;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic [31:0] inst;
    logic [TAG_BITS-1:0] dest_reg_idx;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } IS_PACKET;
  localparam IS_PACKET NOP_PACKET = '{valid: 1'b0, pc: '0, inst: 32'h0000_0013, dest_reg_idx: '0, rs1_value: '0, rs2_value: '0};
endpackage

// File: rtl/rs_slot.sv
// rs_slot: one reservation-station entry with dispatch-time CDB bypass, CDB wakeup (lowest port wins) and ready flag
module rs_slot
  import rs_bank_pkg::*;
#(
  parameter int CDB_WIDTH = 2,
  parameter int TAG_W = TAG_BITS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic squash,
  input  logic load,
  input  logic free,
  input  ID_PACKET id_packet_in,
  input  MT2RS_PACKET mt2rs_packet_in,
  input  logic [TAG_W-1:0] rob_tag_in,
  input  logic [CDB_WIDTH-1:0] cdb_valid,
  input  logic [CDB_WIDTH-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_WIDTH-1:0][XLEN-1:0] cdb_value,
  output logic busy,
  output logic ready,
  output IS_PACKET packet
);
  logic [TAG_W-1:0] tag1, tag2, in_tag1, in_tag2, nxt_tag1, nxt_tag2;
  logic [XLEN-1:0] nxt_val1, nxt_val2;
  always_comb begin
    in_tag1 = load ? (mt2rs_packet_in.rs1_ready ? '0 : mt2rs_packet_in.rs1_tag) : tag1;
    in_tag2 = load ? (mt2rs_packet_in.rs2_ready ? '0 : mt2rs_packet_in.rs2_tag) : tag2;
    nxt_tag1 = in_tag1;
    nxt_tag2 = in_tag2;
    nxt_val1 = load ? id_packet_in.rs1_value : packet.rs1_value;
    nxt_val2 = load ? id_packet_in.rs2_value : packet.rs2_value;
    for (int k = CDB_WIDTH - 1; k >= 0; k--) begin
      if (cdb_valid[k] && in_tag1 != '0 && cdb_tag[k] == in_tag1) begin
        nxt_tag1 = '0;
        nxt_val1 = cdb_value[k];
      end
      if (cdb_valid[k] && in_tag2 != '0 && cdb_tag[k] == in_tag2) begin
        nxt_tag2 = '0;
        nxt_val2 = cdb_value[k];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n || squash) begin
      busy <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      packet <= NOP_PACKET;
    end else if (load) begin
      busy <= 1'b1;
      tag1 <= nxt_tag1;
      tag2 <= nxt_tag2;
      packet <= '{valid: 1'b1, pc: id_packet_in.pc, inst: id_packet_in.inst, dest_reg_idx: rob_tag_in,
                  rs1_value: nxt_val1, rs2_value: nxt_val2};
    end else begin
      busy <= busy && !free;
      tag1 <= nxt_tag1;
      tag2 <= nxt_tag2;
      packet.rs1_value <= nxt_val1;
      packet.rs2_value <= nxt_val2;
    end
  end
  assign ready = busy && tag1 == '0 && tag2 == '0;
endmodule

// File: rtl/rs_bank.sv
// rs_bank: RS_DEPTH-entry reservation station, lowest-free dispatch, select lowest-index ready (oldest ready when RS_AGE_SELECT_EN)
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int CDB_WIDTH = 2,
  parameter int TAG_W = $clog2(ROB_LEN)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic dispatch_valid,
  input  ID_PACKET id_packet_in,
  input  MT2RS_PACKET mt2rs_packet_in,
  input  logic [TAG_W-1:0] rob_tag_in,
  input  logic [CDB_WIDTH-1:0] cdb_valid,
  input  logic [CDB_WIDTH-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_WIDTH-1:0][XLEN-1:0] cdb_value,
  input  logic issue_ready,
  input  logic squash,
  output logic dispatch_ready,
  output logic issue_valid,
  output IS_PACKET issue_packet,
  output logic [$clog2(RS_DEPTH):0] free_count
);
  localparam int IW = $clog2(RS_DEPTH);
  logic [RS_DEPTH-1:0] busy, ready, load, free;
  IS_PACKET pkts [RS_DEPTH];
  logic [IW-1:0] free_idx, sel;
  logic do_disp, do_issue;
  always_comb begin
    free_idx = '0;
    free_count = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      free_idx = busy[i] ? free_idx : IW'(i);
      free_count = free_count + (IW+1)'(!busy[i]);
    end
  end
`ifdef RS_AGE_SELECT_EN
  logic [IW-1:0] rank [RS_DEPTH];
  logic [IW-1:0] best;
  logic found;
  always_comb begin
    sel = '0;
    best = '0;
    found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready[i] && (!found || rank[i] > best)) begin
        sel = IW'(i);
        best = rank[i];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!reset_n || squash || load[i]) rank[i] <= '0;
      else if (busy[i] && !free[i]) rank[i] <= rank[i] + IW'(do_disp) - IW'(do_issue && rank[i] > rank[sel]);
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) sel = ready[i] ? IW'(i) : sel;
  end
`endif
  assign dispatch_ready = !(&busy);
  assign issue_valid = |ready;
  assign issue_packet = issue_valid ? pkts[sel] : NOP_PACKET;
  assign do_disp = dispatch_valid && dispatch_ready && !squash;
  assign do_issue = issue_valid && issue_ready && !squash;
  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_slot
    assign load[g] = do_disp && free_idx == IW'(g);
    assign free[g] = do_issue && sel == IW'(g);
    rs_slot #(.CDB_WIDTH(CDB_WIDTH), .TAG_W(TAG_W)) u_slot (
      .clock(clock), .reset_n(reset_n), .squash(squash), .load(load[g]), .free(free[g]),
      .id_packet_in(id_packet_in), .mt2rs_packet_in(mt2rs_packet_in), .rob_tag_in(rob_tag_in),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .busy(busy[g]), .ready(ready[g]), .packet(pkts[g])
    );
  end
endmodule

// File: doc/rs_bank.md
# rs_bank

Parametrised reservation-station bank that replaces per-slot instantiation in the dispatch/issue path. It holds up to `RS_DEPTH` waiting instructions, accepts one dispatch per cycle and captures operands from `CDB_WIDTH` parallel broadcast ports. It selects one ready instruction per cycle for issue under a valid/ready handshake and flushes on branch squash. It sits between the decoder/map table/ROB (dispatch side) and the functional-unit issue register.

## Interface
Parameters:
- `RS_DEPTH`, 8: number of entries; power of two, ≥2.
- `CDB_WIDTH`, 2: number of CDB broadcast ports.
- `TAG_W`, `$clog2(ROB_LEN)`: ROB tag width. Tag 0 means "value ready".

Ports. One clock; reset is synchronous and active-low.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `dispatch_valid` in 1: dispatch request this cycle.
- `id_packet_in` in ID_PACKET: decoded instruction and register-file operand values.
- `mt2rs_packet_in` in MT2RS_PACKET: per-source ready bits and tags.
- `rob_tag_in` in TAG_W: destination ROB entry. Written into `dest_reg_idx`.
- `cdb_valid` in CDB_WIDTH: per-port broadcast valid.
- `cdb_tag` in CDB_WIDTH×TAG_W: broadcast tags.
- `cdb_value` in CDB_WIDTH×XLEN: broadcast values.
- `issue_ready` in 1: downstream can accept this cycle.
- `squash` in 1: flush all entries.
- `dispatch_ready` out 1: at least one free entry.
- `issue_valid` out 1: `issue_packet` holds a ready instruction.
- `issue_packet` out IS_PACKET: selected instruction with resolved `rs1_value` and `rs2_value`.
- `free_count` out `$clog2(RS_DEPTH)+1`: number of free entries.

## Operation
- Entry state: busy bit, IS_PACKET, `rs1_tag`, `rs2_tag`, and an age rank.
- An entry is ready when it is busy and `rs1_tag==0` and `rs2_tag==0`.
- **Dispatch.** When `dispatch_valid && dispatch_ready && !squash`, write the lowest-index free entry.
  - Source tag = 0 if the map table marks it ready, otherwise the map-table tag.
  - Value = `id_packet_in` value when the tag is 0.
  - Same-cycle CDB bypass: if a source tag equals a valid `cdb_tag[k]`, the tag is stored as 0 and the value as `cdb_value[k]`.
  - `dispatch_valid` while full: the request is ignored, with no state change.
- **Wakeup.** A busy entry compares each nonzero source tag against every valid CDB port. On a match it stores the value and clears the tag.
  - Tag 0 never matches.
  - Duplicate tags across ports: the lowest port index wins.
- **Select.** `issue_valid` = any entry ready. `issue_packet` is the ready entry chosen by the select policy (see Configuration).
- **Issue.** When `issue_valid && issue_ready`, the selected entry's busy bit clears at the edge.
- **Squash.** All busy bits and tags clear at the next edge. Dispatch and issue in that cycle are discarded.
- **Priority per edge.** `reset_n` low, then `squash`, then issue-free together with dispatch-write. A freed slot is not reusable in the same cycle.

## Timing
- Reset values:
  - all entries not busy, tags 0, packets NOP-equivalent (`valid=0`);
  - `issue_valid=0`;
  - `dispatch_ready=1`;
  - `free_count=RS_DEPTH`.
- `dispatch_ready` and `free_count` are derived from registered busy bits only and do not count same-cycle frees.
- Dispatch to earliest issue: 1 cycle (ready sources or bypass hit).
- CDB wakeup to earliest issue: 1 cycle.
- `issue_valid` and `issue_packet` are combinational from registered state. They hold stable while `issue_ready` is low, unless a newly ready older entry overtakes under age select.
- Reset mid-operation drops all entries. No output glitch follows the reset edge.

## Configuration
- `RS_AGE_SELECT_EN` defined:
  - each entry carries an age rank;
  - the oldest ready entry issues;
  - on dispatch, the new entry takes rank 0 and all busy entries with equal or greater rank increment;
  - on free, entries older than the freed entry decrement.
- Not defined: lowest-index ready entry issues, no age state is kept, and starvation is possible.

## Structure
- Shared package: ID_PACKET, IS_PACKET, MT2RS_PACKET, `ROB_LEN`, `XLEN`, and the NOP packet constant for reset.
- Sub-module `rs_slot`: one entry's storage, CDB compare/capture for `CDB_WIDTH` ports, the dispatch bypass and the `ready` output. `rs_bank` instantiates `RS_DEPTH` slots plus the free-slot priority encoder, the select logic and `free_count`.

## Test plan
- Reset then dispatch `add`, both sources ready, `rob_tag=3` -> next cycle `issue_valid=1`, `dest_reg_idx=3`. With `issue_ready=1`, `free_count` returns to 8.
- Dispatch with `rs1_tag=5`; two cycles later `cdb_valid[1]=1`, `cdb_tag[1]=5`, `cdb_value[1]=0xDEAD` -> issue the next cycle with `rs1_value=0xDEAD`.
- Dispatch with `rs2_tag=7` while port 0 broadcasts tag 7 value `0x42` in the same cycle -> entry issues the next cycle with `rs2_value=0x42`.
- Fill 8 entries with unresolved tags -> `dispatch_ready=0`; a 9th `dispatch_valid` is ignored. A squash empties the bank and `free_count=8` the next cycle.
- With `RS_AGE_SELECT_EN`: dispatch A(tag 4) into slot 0 and B(ready) into slot 1, free slot 0, then dispatch C(ready) into slot 0 -> B issues before C. Without the macro, C issues first.
- Hold `issue_ready=0` for 3 cycles with one ready entry -> `issue_packet` stays stable and `free_count` stays unchanged.
